memory_fill_responder: RTL

MEMORY_FILL_RESPONDER -- requirements
Module: memory_fill_responder

---
 rtl/memory_fill_responder.sv | 111 +++++++++++
 1 files changed

// File: rtl/memory_fill_responder.sv
// Block-fill memory responder: 8-beat reads and single-word writes after LATENCY cycles.
// Define FILL_CRITICAL_WORD_FIRST_EN to start each burst at the requested word offset.
module memory_fill_responder #(
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemoryRequest,
  input  logic [15:0] MemoryAddressIn,
  input  logic        MemoryWriteEnable,
  input  logic [15:0] MemoryDataIn,
  output logic [15:0] MemoryDataOut,
  output logic        DataValid,
  output logic [2:0]  WordOffset,
  output logic        MemoryStall
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_BURST, WR_WAIT} state_t;

  localparam logic [3:0] RD_WAIT_LAST = 4'(LATENCY - 2);
  localparam logic [3:0] WR_WAIT_LAST = 4'(LATENCY - 1);

  state_t      state;
  state_t      state_next;
  logic [14:0] word_addr;
  logic [15:0] wr_data;
  logic [3:0]  wait_cnt;
  logic [2:0]  beat_cnt;
  logic [2:0]  start_offset;
  logic [2:0]  next_offset;
  logic        accept;
  logic        commit_write;
  logic        unused_addr_bit;
  logic [15:0] mem [32768];

  assign unused_addr_bit = MemoryAddressIn[0];
  assign accept          = (state == IDLE) && MemoryRequest;
  assign commit_write    = !rst && (state == WR_WAIT) && (wait_cnt == WR_WAIT_LAST);
  assign next_offset     = WordOffset + 3'd1;
  assign MemoryStall     = (state != IDLE);

`ifdef FILL_CRITICAL_WORD_FIRST_EN
  assign start_offset = word_addr[2:0];
`else
  assign start_offset = 3'd0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (MemoryRequest) state_next = MemoryWriteEnable ? WR_WAIT : RD_WAIT;
      RD_WAIT:  if (wait_cnt == RD_WAIT_LAST) state_next = RD_BURST;
      RD_BURST: if (beat_cnt == 3'd7) state_next = IDLE;
      WR_WAIT:  if (wait_cnt == WR_WAIT_LAST) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      wait_cnt      <= 4'd0;
      beat_cnt      <= 3'd0;
      DataValid     <= 1'b0;
      WordOffset    <= 3'd0;
      MemoryDataOut <= 16'd0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (MemoryRequest) wait_cnt <= 4'd0;
        RD_WAIT: begin
          wait_cnt <= wait_cnt + 4'd1;
          // Data is registered one edge ahead so the first beat lands in cycle LATENCY.
          if (state_next == RD_BURST) begin
            beat_cnt      <= 3'd0;
            DataValid     <= 1'b1;
            WordOffset    <= start_offset;
            MemoryDataOut <= mem[{word_addr[14:3], start_offset}];
          end
        end
        RD_BURST: begin
          if (beat_cnt == 3'd7) begin
            beat_cnt      <= 3'd0;
            DataValid     <= 1'b0;
            WordOffset    <= 3'd0;
            MemoryDataOut <= 16'd0;
          end else begin
            beat_cnt      <= beat_cnt + 3'd1;
            WordOffset    <= next_offset;
            MemoryDataOut <= mem[{word_addr[14:3], next_offset}];
          end
        end
        WR_WAIT: wait_cnt <= wait_cnt + 4'd1;
        default: ;
      endcase
    end
  end

  // Request fields are held only from acceptance; no reset needed.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      word_addr <= MemoryAddressIn[15:1];
      wr_data   <= MemoryDataIn;
    end
  end

  always_ff @(posedge clk) begin
    if (commit_write) mem[word_addr] <= wr_data;
  end

endmodule
